// File: rtl/cmd_pkg.sv
// rtl/cmd_pkg.sv - shared types for the register-file command path
package cmd_pkg;

   localparam int ID_W = 3;

   typedef enum logic {
      ARB    = 1'b0,
      LOCKED = 1'b1
   } arb_state_t;

   typedef struct packed {
      logic            vld;
      logic [ID_W-1:0] id;
   } rd_tag_t;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/regfile_arbiter_rr_pick.sv
// rtl/regfile_arbiter_rr_pick.sv - round-robin pick of the first valid index at or after ptr
module rr_pick
   import cmd_pkg::*;
#(
   parameter int N  = 2,
   parameter int IW = idx_width(N)
) (
   input  logic [N-1:0]  valid,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          any
);

   logic [IW-1:0] cand;

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      cand  = '0;
      for (int i = 0; i < N; i++) begin
         cand = IW'((int'(ptr) + i) % N);
         if (!any && valid[cand]) begin
            grant[cand] = 1'b1;
            idx         = cand;
            any         = 1'b1;
         end
      end
   end

endmodule

// File: rtl/regfile_arbiter.sv
// rtl/regfile_arbiter.sv - round-robin arbiter with lock support in front of a single-port register file
module regfile_arbiter
   import cmd_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 8,
   parameter int MEM_RD_LAT = 1,
   parameter int LOCK_TO    = 255
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ-1:0]        req_we,
   input  logic [NUM_REQ-1:0]        req_lock,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_rdata,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic                      mem_write_en,
   output logic [DATA_W-1:0]         mem_write_data,
   output logic                      mem_read_en,
   input  logic [DATA_W-1:0]         mem_read_data,
   output logic                      locked,
   output logic                      lock_to_err
);

   localparam int IW = idx_width(NUM_REQ);
   localparam int CW = $clog2(LOCK_TO + 1);

   arb_state_t         state, state_nxt;
   logic [IW-1:0]      owner, owner_nxt;
   logic [IW-1:0]      rr_ptr;
   logic [CW-1:0]      idle_cnt;
   logic               timeout;
   logic [NUM_REQ-1:0] cand_valid;
   logic [NUM_REQ-1:0] grant;
   logic [IW-1:0]      win;
   logic               any;
   logic               win_we;
   rd_tag_t            tag_pipe [MEM_RD_LAT];

   rr_pick #(
      .N  (NUM_REQ),
      .IW (IW)
   ) u_rr_pick (
      .valid (cand_valid),
      .ptr   (rr_ptr),
      .grant (grant),
      .idx   (win),
      .any   (any)
   );

   assign req_ready = grant;
   assign win_we    = req_we[win];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ARB;
         owner <= '0;
      end else begin
         state <= state_nxt;
         owner <= owner_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      case (state)
         ARB: begin
            if (any && req_lock[win]) begin
               state_nxt = LOCKED;
               owner_nxt = win;
            end
         end
         LOCKED: begin
            if (timeout || (any && !req_lock[win]))
               state_nxt = ARB;
         end
         default: state_nxt = ARB;
      endcase
   end

   // The timeout cycle is itself the LOCK_TO-th idle cycle and grants no one.
   always_comb begin
      locked      = (state == LOCKED);
      timeout     = locked && (idle_cnt == CW'(LOCK_TO - 1));
      lock_to_err = timeout;
      cand_valid  = req_valid;
      if (locked)
         cand_valid = timeout ? '0 : (req_valid & (NUM_REQ'(1) << owner));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         rr_ptr <= '0;
      else if (!locked && any)
         rr_ptr <= (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         idle_cnt <= '0;
      else if (locked && !any && !timeout)
         idle_cnt <= idle_cnt + 1'b1;
      else
         idle_cnt <= '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_addr       <= '0;
         mem_write_en   <= 1'b0;
         mem_write_data <= '0;
         mem_read_en    <= 1'b0;
      end else begin
         mem_write_en <= any && win_we;
         mem_read_en  <= any && !win_we;
         if (any)
            mem_addr <= req_addr[int'(win)*ADDR_W +: ADDR_W];
         if (any && win_we)
            mem_write_data <= req_wdata[int'(win)*DATA_W +: DATA_W];
      end
   end

   // Read tags ride alongside the memory latency so responses return in issue order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < MEM_RD_LAT; k++)
            tag_pipe[k] <= '0;
         rsp_valid <= '0;
         rsp_rdata <= '0;
      end else begin
         tag_pipe[0] <= '{vld: any && !win_we, id: ID_W'(win)};
         for (int k = 1; k < MEM_RD_LAT; k++)
            tag_pipe[k] <= tag_pipe[k-1];
         if (tag_pipe[MEM_RD_LAT-1].vld) begin
            rsp_valid <= NUM_REQ'(1) << tag_pipe[MEM_RD_LAT-1].id;
            rsp_rdata <= mem_read_data;
         end else begin
            rsp_valid <= '0;
         end
      end
   end

endmodule

// File: tb/tb_regfile_arbiter.sv
// tb/tb_regfile_arbiter.sv - directed bench: one instance at read latency 1, one at latency 3
module tb_regfile_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req_valid, req_we, req_lock;
   logic [15:0] req_addr, req_wdata;
   logic [1:0]  ready_a, ready_b, rsp_valid_a, rsp_valid_b;
   logic [7:0]  rsp_rdata_a, rsp_rdata_b, mem_addr_a, mem_addr_b;
   logic [7:0]  mem_wd_a, mem_wd_b, mem_rd_a, mem_rd_b, rd_d1, rd_d2;
   logic        mem_we_a, mem_we_b, mem_re_a, mem_re_b;
   logic        locked_a, locked_b, lto_a, lto_b;
   int          n_tests = 0;
   int          n_fail  = 0;

   always #5 clk = ~clk;

   // Register file contents are addr ^ 0xB5 (so mem[0x10] = 0xA5).
   assign mem_rd_a = mem_addr_a ^ 8'hB5;
   always @(posedge clk) begin
      rd_d1 <= mem_addr_b ^ 8'hB5;
      rd_d2 <= rd_d1;
   end
   assign mem_rd_b = rd_d2;

   regfile_arbiter #(
      .NUM_REQ(2), .ADDR_W(8), .DATA_W(8), .MEM_RD_LAT(1), .LOCK_TO(8)
   ) u_dut_a (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(ready_a), .req_we(req_we), .req_lock(req_lock),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a),
      .mem_addr(mem_addr_a), .mem_write_en(mem_we_a), .mem_write_data(mem_wd_a),
      .mem_read_en(mem_re_a), .mem_read_data(mem_rd_a),
      .locked(locked_a), .lock_to_err(lto_a)
   );

   regfile_arbiter #(
      .NUM_REQ(2), .ADDR_W(8), .DATA_W(8), .MEM_RD_LAT(3), .LOCK_TO(8)
   ) u_dut_b (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(ready_b), .req_we(req_we), .req_lock(req_lock),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b),
      .mem_addr(mem_addr_b), .mem_write_en(mem_we_b), .mem_write_data(mem_wd_b),
      .mem_read_en(mem_re_b), .mem_read_data(mem_rd_b),
      .locked(locked_b), .lock_to_err(lto_b)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   initial begin
      rst = 1'b1; req_valid = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_ready", ready_a, 0);
      chk("rst_rsp", rsp_valid_a, 0);
      chk("rst_strobes", {mem_we_a, mem_re_a}, 0);
      chk("rst_addr", mem_addr_a, 0);
      chk("rst_lock", {locked_a, lto_a}, 0);
      @(negedge clk); rst = 1'b0;

      // single read of 0x10 by req0
      @(negedge clk); req_valid = 2'b01; req_addr[7:0] = 8'h10; #1;
      chk("rd_ready", ready_a, 2'b01);
      @(negedge clk); req_valid = 2'b00; #1;
      chk("rd_strobe", {mem_we_a, mem_re_a}, 2'b01);
      chk("rd_addr", mem_addr_a, 8'h10);
      chk("rd_rsp_early", rsp_valid_a, 0);
      @(negedge clk); #1;
      chk("rd_rsp", rsp_valid_a, 2'b01);
      chk("rd_data", rsp_rdata_a, 8'hA5);
      chk("rd_strobe_off", mem_re_a, 0);
      @(negedge clk); #1;
      chk("rd_rsp_pulse", rsp_valid_a, 0);
      chk("rd_rsp_b_early", rsp_valid_b, 0);
      @(negedge clk); #1;
      chk("rd_rsp_b", rsp_valid_b, 2'b01);
      chk("rd_data_b", rsp_rdata_b, 8'hA5);

      // lock by req0, then idle until forced release; req1 waits
      @(negedge clk); req_valid = 2'b01; req_lock = 2'b01; req_addr[7:0] = 8'h40; #1;
      chk("to_grant", ready_a, 2'b01);
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         if (k == 1) begin
            req_valid = 2'b10; req_lock = 2'b00; req_addr[15:8] = 8'h41;
         end
         #1;
         chk($sformatf("to_wait_ready_%0d", k), ready_a, 0);
         chk($sformatf("to_wait_err_%0d", k), {locked_a, lto_a}, 2'b10);
      end
      @(negedge clk); #1;
      chk("to_err", lto_a, 1);
      chk("to_err_ready", ready_a, 0);
      @(negedge clk); #1;
      chk("to_after_ready", ready_a, 2'b10);
      chk("to_after_lock", {locked_a, lto_a}, 0);

      // contention with pointer at 0
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (k == 0) begin
            req_valid = 2'b11; req_addr = 16'h5150;
         end
         #1;
         chk($sformatf("cont_ready_%0d", k), ready_a, (k % 2 == 0) ? 2'b01 : 2'b10);
         if (k >= 2) begin
            chk($sformatf("cont_rsp_%0d", k), rsp_valid_a, (k % 2 == 0) ? 2'b01 : 2'b10);
            chk($sformatf("cont_data_%0d", k), rsp_rdata_a, (k % 2 == 0) ? 8'hE5 : 8'hE4);
         end
      end

      // locked read-modify-write by req1, req0 held off
      @(negedge clk); req_valid = 2'b10; req_lock = 2'b10; req_addr[15:8] = 8'h20; #1;
      chk("rmw_lock_grant", ready_a, 2'b10);
      @(negedge clk); req_valid = 2'b01; req_lock = 2'b00; req_addr[7:0] = 8'h60; #1;
      chk("rmw_blk_0", ready_a, 0);
      chk("rmw_rd_issue", {mem_re_a, mem_addr_a}, {1'b1, 8'h20});
      chk("rmw_locked", locked_a, 1);
      @(negedge clk); #1;
      chk("rmw_blk_1", ready_a, 0);
      chk("rmw_rsp", rsp_valid_a, 2'b10);
      chk("rmw_data", rsp_rdata_a, 8'h95);
      @(negedge clk);
      req_valid = 2'b11; req_we = 2'b10; req_addr[15:8] = 8'h21; req_wdata[15:8] = 8'h3C; #1;
      chk("rmw_wr_grant", ready_a, 2'b10);
      @(negedge clk); req_valid = 2'b01; req_we = 2'b00; #1;
      chk("rmw_req0_grant", ready_a, 2'b01);
      chk("rmw_wr_strobe", {mem_we_a, mem_re_a}, 2'b10);
      chk("rmw_wr_addr", mem_addr_a, 8'h21);
      chk("rmw_wr_data", mem_wd_a, 8'h3C);
      chk("rmw_unlocked", locked_a, 0);
      @(negedge clk); req_valid = 2'b00; #1;
      chk("rmw_rd0_strobe", {mem_we_a, mem_re_a}, 2'b01);
      chk("rmw_rd0_addr", mem_addr_a, 8'h60);

      // four back-to-back reads through the latency-3 instance
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (k < 4) begin
            req_valid = 2'b01 << (k % 2);
            if (k % 2 == 0) req_addr[7:0] = 8'(k);
            else            req_addr[15:8] = 8'(k);
         end else begin
            req_valid = 2'b00;
         end
         #1;
         if (k < 4)
            chk($sformatf("pipe_ready_%0d", k), ready_b, 2'b01 << (k % 2));
         if (k == 3)
            chk("pipe_rsp_idle", rsp_valid_b, 0);
         if (k >= 4) begin
            chk($sformatf("pipe_rsp_%0d", k - 4), rsp_valid_b, 2'b01 << (k % 2));
            chk($sformatf("pipe_data_%0d", k - 4), rsp_rdata_b, 8'(k - 4) ^ 8'hB5);
         end
      end
      @(negedge clk); #1;
      chk("pipe_rsp_end", rsp_valid_b, 0);

      // reset with reads in flight
      @(negedge clk); req_valid = 2'b10; req_addr[15:8] = 8'h71;
      @(negedge clk); req_valid = 2'b01; req_addr[7:0] = 8'h70;
      @(negedge clk); req_valid = 2'b00; rst = 1'b1; #1;
      chk("mid_rst_rsp", {rsp_valid_b, rsp_valid_a}, 0);
      chk("mid_rst_strobes", {mem_we_a, mem_re_a, mem_we_b, mem_re_b}, 0);
      chk("mid_rst_addr", mem_addr_a, 0);
      chk("mid_rst_rdata", rsp_rdata_a, 0);
      chk("mid_rst_wdata", mem_wd_a, 0);
      @(negedge clk);
      @(negedge clk); rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk); #1;
         chk($sformatf("post_rst_rsp_%0d", k), {rsp_valid_b, rsp_valid_a}, 0);
      end
      @(negedge clk); req_valid = 2'b11; req_addr = 16'h7372; #1;
      chk("post_rst_grant_a", ready_a, 2'b01);
      chk("post_rst_grant_b", ready_b, 2'b01);
      @(negedge clk); req_valid = 2'b00; #1;
      chk("post_rst_issue", {mem_re_a, mem_addr_a}, {1'b1, 8'h72});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
